// File: rtl/register_file_dump_if.sv
// register_file_dump_if
// Purpose: groups the dump engine's control and stream handshake signals so
//          the register file and the debug transmitter share one bundle.
// Signals:
//   dump_start  request a full dump (consumer -> register file)
//   dump_ready  consumer accepts the current beat
//   dump_valid  current beat is valid
//   dump_addr   entry index of the current beat
//   dump_data   entry value of the current beat
//   dump_busy   dump in progress
//   dump_done   one-cycle pulse after the last beat is accepted
// Modports: master = register file (beat producer), slave = consumer.
interface register_file_dump_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              dump_start;
  logic              dump_ready;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_addr;
  logic [WIDTH-1:0]  dump_data;
  logic              dump_busy;
  logic              dump_done;

  modport master (
    input  dump_start,
    input  dump_ready,
    output dump_valid,
    output dump_addr,
    output dump_data,
    output dump_busy,
    output dump_done
  );

  modport slave (
    output dump_start,
    output dump_ready,
    input  dump_valid,
    input  dump_addr,
    input  dump_data,
    input  dump_busy,
    input  dump_done
  );
endinterface

// File: rtl/register_file_dump.sv
// register_file_dump
// Purpose: parametrised CPU register file with two combinational read ports,
//          optional write-to-read bypass, optional hardwired-zero entry 0 and
//          a handshaked engine that streams every entry in address order.
// Parameters: WIDTH, DEPTH (2..256), ADDR_W (derived), ZERO_REG, BYPASS.
// Ports:
//   clk                  rising-edge clock
//   reset                asynchronous, active-low; clears all state
//   write_enable         write strobe
//   Destination_select   write address
//   DATA                 write data
//   Source_select_0/1    read addresses
//   out_0/out_1          combinational read data
//   dump                 dump stream bundle (master side)
module register_file_dump #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_enable,
  input  logic [ADDR_W-1:0]    Destination_select,
  input  logic [WIDTH-1:0]     DATA,
  input  logic [ADDR_W-1:0]    Source_select_0,
  input  logic [ADDR_W-1:0]    Source_select_1,
  output logic [WIDTH-1:0]     out_0,
  output logic [WIDTH-1:0]     out_1,
  register_file_dump_if.master dump
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              write_ok;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] load_addr;
  logic [WIDTH-1:0]  load_data;

  // An address is backed by storage only if it is below DEPTH (DEPTH need not
  // be a power of two) and is not the hardwired-zero entry.
  function automatic logic addr_backed(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Shared by both read ports and the dump load so they can never disagree.
  function automatic logic [WIDTH-1:0] resolve(
    input logic [ADDR_W-1:0] a,
    input logic [WIDTH-1:0]  stored,
    input logic              wr_ok,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [WIDTH-1:0]  wr_data
  );
    if (!addr_backed(a)) begin
      return '0;
    end
    if ((BYPASS != 0) && wr_ok && (wr_addr == a)) begin
      return wr_data;
    end
    return stored;
  endfunction

  always_comb begin
    write_ok = write_enable && addr_backed(Destination_select);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_ok) begin
      mem[Destination_select] <= DATA;
    end
  end

  always_comb begin
    out_0 = resolve(Source_select_0, mem[Source_select_0], write_ok, Destination_select, DATA);
    out_1 = resolve(Source_select_1, mem[Source_select_1], write_ok, Destination_select, DATA);
  end

  // IDLE always loads entry 0; SEND loads the entry after the current beat.
  // In SEND on the last beat the wrapped address is computed but never used.
  always_comb begin
    load_addr = (state_q == IDLE) ? '0 : addr_q + ADDR_W'(1);
    load_data = resolve(load_addr, mem[load_addr], write_ok, Destination_select, DATA);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // A stalled beat keeps its captured data even if the entry is rewritten.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dump.dump_start) begin
          state_d = SEND;
          addr_d  = '0;
          data_d  = load_data;
        end
      end
      SEND: begin
        if (dump.dump_ready) begin
          if (addr_q == LAST_ADDR) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d = load_addr;
            data_d = load_data;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dump.dump_valid = (state_q == SEND);
  assign dump.dump_busy  = (state_q == SEND);
  assign dump.dump_addr  = addr_q;
  assign dump.dump_data  = data_q;
  assign dump.dump_done  = done_q;

endmodule

// File: tb/tb_register_file_dump.sv
// tb_register_file_dump
// Purpose: directed self-checking bench. dut_a uses the default configuration
//          (32 entries, zero entry, bypass on); dut_b uses 20 entries with no
//          zero entry and no bypass. Both share clock and reset.
module tb_register_file_dump;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        we_a, we_b;
  logic [4:0]  dst_a, dst_b, src0_a, src1_a, src0_b, src1_b;
  logic [31:0] data_a, data_b;
  logic [31:0] out0_a, out1_a, out0_b, out1_b;

  int checks = 0;
  int errors = 0;

  register_file_dump_if #(.WIDTH(32), .ADDR_W(5)) dif_a ();
  register_file_dump_if #(.WIDTH(32), .ADDR_W(5)) dif_b ();

  register_file_dump dut_a (
    .clk                (clk),
    .reset              (reset),
    .write_enable       (we_a),
    .Destination_select (dst_a),
    .DATA               (data_a),
    .Source_select_0    (src0_a),
    .Source_select_1    (src1_a),
    .out_0              (out0_a),
    .out_1              (out1_a),
    .dump               (dif_a)
  );

  register_file_dump #(.DEPTH(20), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk                (clk),
    .reset              (reset),
    .write_enable       (we_b),
    .Destination_select (dst_b),
    .DATA               (data_b),
    .Source_select_0    (src0_b),
    .Source_select_1    (src1_b),
    .out_0              (out0_b),
    .out_1              (out1_b),
    .dump               (dif_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wa, input logic [4:0] da, input logic [31:0] va,
                               input logic wb, input logic [4:0] db, input logic [31:0] vb);
    we_a = wa; dst_a = da; data_a = va;
    we_b = wb; dst_b = db; data_b = vb;
    nextCycle();
    we_a = 1'b0;
    we_b = 1'b0;
  endtask

  initial begin
    int idx;
    int cyc;
    logic rdy;

    we_a = 0; dst_a = 0; data_a = 0; src0_a = 0; src1_a = 5;
    we_b = 0; dst_b = 0; data_b = 0; src0_b = 0; src1_b = 5;
    dif_a.dump_start = 0; dif_a.dump_ready = 0;
    dif_b.dump_start = 0; dif_b.dump_ready = 0;

    // Reset state
    #2 reset = 1'b0;
    #1;
    checkOutput("reset valid", 32'(dif_a.dump_valid), 32'd0);
    checkOutput("reset busy",  32'(dif_a.dump_busy),  32'd0);
    checkOutput("reset done",  32'(dif_a.dump_done),  32'd0);
    checkOutput("reset addr",  32'(dif_a.dump_addr),  32'd0);
    checkOutput("reset data",  dif_a.dump_data,       32'd0);
    checkOutput("reset read",  out1_a,                32'd0);
    #9 reset = 1'b1;
    nextCycle();

    // Zero entry
    applyStimulus(1, 5'd0, 32'hDEADBEEF, 1, 5'd0, 32'hDEADBEEF);
    applyStimulus(1, 5'd5, 32'h12345678, 1, 5'd5, 32'h12345678);
    src0_a = 0; src1_a = 5; src0_b = 0; src1_b = 5;
    #1;
    checkOutput("a zero entry",   out0_a, 32'd0);
    checkOutput("a entry5",       out1_a, 32'h12345678);
    checkOutput("b entry0 kept",  out0_b, 32'hDEADBEEF);
    checkOutput("b entry5",       out1_b, 32'h12345678);

    // Bypass vs. no bypass
    we_a = 1; dst_a = 7; data_a = 32'hA5A5A5A5; src0_a = 7;
    we_b = 1; dst_b = 7; data_b = 32'hA5A5A5A5; src0_b = 7;
    #1;
    checkOutput("a bypass",    out0_a, 32'hA5A5A5A5);
    checkOutput("b no bypass", out0_b, 32'd0);
    nextCycle();
    we_a = 0; we_b = 0;
    #1;
    checkOutput("b stored after write", out0_b, 32'hA5A5A5A5);
    we_a = 1; dst_a = 0; data_a = 32'hFFFFFFFF; src0_a = 0;
    #1;
    checkOutput("a zero entry no bypass", out0_a, 32'd0);
    nextCycle();
    we_a = 0;

    // Out-of-range address on the 20-entry instance
    we_b = 1; dst_b = 25; data_b = 32'h55555555; src0_b = 25;
    #1;
    checkOutput("b addr25 same cycle", out0_b, 32'd0);
    nextCycle();
    we_b = 0;
    #1;
    checkOutput("b addr25 after", out0_b, 32'd0);

    // Preload entry i = i*3; B sends its surplus writes to address 25
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1, 5'(i), 32'(i * 3),
                    1, (i < 20) ? 5'(i) : 5'd25, (i < 20) ? 32'(i * 3) : 32'hBAD00000 + 32'(i));
    end
    src0_a = 31; src0_b = 19; src1_b = 0;
    #1;
    checkOutput("a entry31", out0_a, 32'd93);
    checkOutput("b entry19", out0_b, 32'd57);
    checkOutput("b entry0",  out1_b, 32'd0);

    // Full dump on both instances, ready held high
    dif_a.dump_ready = 1; dif_b.dump_ready = 1;
    dif_a.dump_start = 1; dif_b.dump_start = 1;
    nextCycle();
    dif_a.dump_start = 0; dif_b.dump_start = 0;
    for (int k = 0; k < 32; k++) begin
      checkOutput("a dump valid", 32'(dif_a.dump_valid), 32'd1);
      checkOutput("a dump busy",  32'(dif_a.dump_busy),  32'd1);
      checkOutput("a dump addr",  32'(dif_a.dump_addr),  32'(k));
      checkOutput("a dump data",  dif_a.dump_data,       32'(k * 3));
      if (k < 20) begin
        checkOutput("b dump addr", 32'(dif_b.dump_addr), 32'(k));
        checkOutput("b dump data", dif_b.dump_data,      32'(k * 3));
      end else if (k == 20) begin
        checkOutput("b dump done",  32'(dif_b.dump_done),  32'd1);
        checkOutput("b dump valid", 32'(dif_b.dump_valid), 32'd0);
      end else begin
        checkOutput("b done once",  32'(dif_b.dump_done),  32'd0);
      end
      nextCycle();
    end
    checkOutput("a done pulse",  32'(dif_a.dump_done),  32'd1);
    checkOutput("a valid after", 32'(dif_a.dump_valid), 32'd0);
    checkOutput("a busy after",  32'(dif_a.dump_busy),  32'd0);

    // Back-to-back start in the done cycle
    dif_a.dump_start = 1;
    nextCycle();
    dif_a.dump_start = 0;
    checkOutput("b2b done cleared", 32'(dif_a.dump_done),  32'd0);
    checkOutput("b2b valid",        32'(dif_a.dump_valid), 32'd1);

    // Back-pressure: accept one cycle in three, overwrite the stalled entry
    idx = 0;
    cyc = 0;
    while (idx < 32 && cyc < 300) begin
      checkOutput("bp valid", 32'(dif_a.dump_valid), 32'd1);
      checkOutput("bp addr",  32'(dif_a.dump_addr),  32'(idx));
      checkOutput("bp data",  dif_a.dump_data,       32'(idx * 3));
      rdy = ((cyc % 3) == 2);
      dif_a.dump_ready = rdy;
      if (!rdy) begin
        we_a = 1; dst_a = 5'(idx); data_a = 32'hFFFFFFFF;
      end else begin
        we_a = 0;
      end
      nextCycle();
      if (rdy) idx++;
      cyc++;
    end
    we_a = 0;
    dif_a.dump_ready = 1;
    checkOutput("bp within budget", 32'(cyc < 300), 32'd1);
    checkOutput("bp done",          32'(dif_a.dump_done),  32'd1);
    checkOutput("bp valid after",   32'(dif_a.dump_valid), 32'd0);
    src0_a = 1; src1_a = 31;
    #1;
    checkOutput("bp entry1 written",  out0_a, 32'hFFFFFFFF);
    checkOutput("bp entry31 written", out1_a, 32'hFFFFFFFF);
    src1_a = 0;
    #1;
    checkOutput("bp entry0 still zero", out1_a, 32'd0);
    nextCycle();

    // Reset in the middle of a dump
    dif_a.dump_start = 1;
    nextCycle();
    dif_a.dump_start = 0;
    repeat (11) nextCycle();
    checkOutput("mid dump addr", 32'(dif_a.dump_addr), 32'd11);
    checkOutput("mid dump data", dif_a.dump_data,      32'hFFFFFFFF);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort valid", 32'(dif_a.dump_valid), 32'd0);
    checkOutput("abort busy",  32'(dif_a.dump_busy),  32'd0);
    checkOutput("abort done",  32'(dif_a.dump_done),  32'd0);
    checkOutput("abort addr",  32'(dif_a.dump_addr),  32'd0);
    checkOutput("abort data",  dif_a.dump_data,       32'd0);
    checkOutput("abort entry cleared", out0_a, 32'd0);
    nextCycle();
    #2 reset = 1'b1;
    nextCycle();
    nextCycle();
    checkOutput("no restart valid", 32'(dif_a.dump_valid), 32'd0);
    checkOutput("no restart done",  32'(dif_a.dump_done),  32'd0);

    // Fresh dump after reset; load-edge writes test bypass capture on each instance
    applyStimulus(1, 5'd4, 32'h00000044, 0, 5'd0, 32'd0);
    dif_a.dump_start = 1; dif_b.dump_start = 1;
    nextCycle();
    dif_a.dump_start = 0; dif_b.dump_start = 0;
    for (int k = 0; k < 32; k++) begin
      checkOutput("fresh addr", 32'(dif_a.dump_addr), 32'(k));
      checkOutput("fresh data", dif_a.dump_data,
                  (k == 4) ? 32'h00000044 : (k == 10) ? 32'h00001010 : 32'd0);
      if (k < 20) begin
        checkOutput("b fresh data", dif_b.dump_data, 32'd0);
      end else if (k == 20) begin
        checkOutput("b fresh done", 32'(dif_b.dump_done), 32'd1);
      end
      if (k == 9) begin
        we_a = 1; dst_a = 10; data_a = 32'h00001010;
        we_b = 1; dst_b = 10; data_b = 32'h00002020;
      end else begin
        we_a = 0; we_b = 0;
      end
      nextCycle();
    end
    we_a = 0; we_b = 0;
    checkOutput("fresh done", 32'(dif_a.dump_done), 32'd1);
    src0_b = 10;
    #1;
    checkOutput("b entry10 stored", out0_b, 32'h00002020);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_dump.md
# register_file_dump

Parametrised successor to the CPU register file. It provides a configurable depth and width, two combinational read ports with optional write-to-read bypass, and an optional hardwired-zero entry 0. It also contains a handshaked dump engine that streams every entry, in address order, to the debug/UART path, replacing the single static debug read port. It sits in the datapath between decode and the ALU; the dump stream feeds the debug transmitter.

## Interface
- WIDTH, 32, data width of each entry
- DEPTH, 32, number of entries (2..256, need not be a power of two)
- ADDR_W, $clog2(DEPTH), derived address width; do not override
- ZERO_REG, 1, when 1 entry 0 always reads 0 and writes to it are dropped
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports and the dump load

- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- write_enable  in  1  write strobe
- Destination_select  in  ADDR_W  write address
- DATA  in  WIDTH  write data
- Source_select_0, Source_select_1  in  ADDR_W  read addresses
- out_0, out_1  out  WIDTH  combinational read data
- dump_start  in  1  request a full dump; sampled only in IDLE
- dump_ready  in  1  consumer accepts the current beat
- dump_valid  out  1  beat valid
- dump_addr  out  ADDR_W  entry index of the current beat
- dump_data  out  WIDTH  entry value of the current beat
- dump_busy  out  1  high from the cycle after dump_start until dump_done
- dump_done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- Storage: DEPTH x WIDTH flops. While reset is low, all entries are 0.
- Write: at a rising edge with write_enable=1, entry[Destination_select] <= DATA.
  - The write is dropped if Destination_select >= DEPTH.
  - The write is dropped if ZERO_REG=1 and Destination_select=0.
- Read port k returns its value by the first matching rule:
  - 0 if the address is >= DEPTH, or if ZERO_REG=1 and the address is 0;
  - DATA if BYPASS=1, write_enable=1, Destination_select equals the address, and the write is not dropped;
  - otherwise the stored entry.
- Dump FSM states: IDLE, SEND.
  - IDLE: when dump_start=1 at an edge, go to SEND with dump_addr <= 0 and dump_data <= load(0).
  - SEND, beat accepted (dump_valid & dump_ready at an edge):
    - if dump_addr = DEPTH-1: go to IDLE and pulse dump_done for the next cycle;
    - else dump_addr <= dump_addr+1 and dump_data <= load(dump_addr+1).
  - SEND, beat not accepted: dump_addr and dump_data hold stable, even if the entry is written meanwhile.
  - dump_start is ignored in SEND.
  - dump_valid = dump_busy = (state == SEND).
- load(a): uses the same rules as a read port at address a, evaluated on that edge. With BYPASS=1, a write to address a on the load edge is captured. With BYPASS=0, the pre-write value is captured.

## Timing
- Read ports: zero latency, purely combinational from addresses, stored state, and (with BYPASS=1) the write inputs.
- Writes become visible in stored state on the cycle after the edge.
- Dump start: dump_start at edge N gives dump_valid=1 in cycle N+1.
- Dump throughput: with dump_ready held high, one beat per cycle, DEPTH beats total. The last beat is accepted at edge N+DEPTH, dump_done=1 in cycle N+DEPTH+1, and dump_valid=0 in that same cycle.
- Back-to-back dumps: dump_start is legal in the same cycle dump_done is high, and the new dump is accepted that cycle.
- Reset values, asynchronous:
  - all entries 0;
  - dump_valid, dump_busy, dump_done 0;
  - dump_addr 0; dump_data 0;
  - state IDLE.
- Reset mid-dump: the dump aborts immediately, no dump_done is issued, and a new dump_start is required after release.
- Simultaneous write and read of the same address is defined by BYPASS. Simultaneous write and dump is defined by load().

## Test plan
- Reset and zero entry: after reset, write 0xDEADBEEF to entry 0 and 0x12345678 to entry 5. Then out_0(sel 0)=0, out_1(sel 5)=0x12345678. With ZERO_REG=0, sel 0 reads 0xDEADBEEF.
- Bypass: write_enable=1, Destination_select=7, DATA=0xA5A5A5A5, Source_select_0=7 in the same cycle. Then out_0=0xA5A5A5A5 with BYPASS=1, and the old value 0 with BYPASS=0.
- Full dump: preload entry i = i*3, dump_ready=1, pulse dump_start. Expect 32 consecutive beats (addr i, data i*3; beat 0 = 0 with ZERO_REG=1), dump_done one cycle after the last beat, and dump_busy low after it.
- Back-pressure: toggle dump_ready with a 1-of-3 duty and write entry[dump_addr]=0xFFFFFFFF while stalled. dump_data stays unchanged until accepted, and no beats are lost or duplicated.
- Reset mid-dump: assert reset after beat 10. All dump outputs go to 0 immediately. After release a fresh dump starts at addr 0, and all entries read 0.
- Odd depth: DEPTH=20. Reads and writes at address 25 return 0 and are dropped, and the dump produces exactly 20 beats.
